// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit path: parity encodings, FSM states
// and the default baud divisor.
package uart_tx_fifo_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam logic [1:0] PAR_MARK = 2'b11;

    // 27 MHz system clock at 115200 baud
    localparam int DEFAULT_DIV = 234;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous show-ahead FIFO with occupancy counter; shared by the UART
// transmitter and receiver.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full/empty come from the count so wrapped pointers are never ambiguous
    assign full     = (level == (AW+1)'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: word FIFO feeding a start/data/parity/stop FSM
// with a runtime divisor and frame format latched per frame.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DIV_W-1:0]              cfg_div,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_W - 1);

    tx_state_e         state;
    tx_state_e         state_nxt;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic [DATA_W-1:0] head;
    logic [DIV_W-1:0]  bit_cnt;
    logic [DIV_W-1:0]  div_lat;
    logic [IDX_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shift;
    logic [1:0]        par_lat;
    logic              stop2_lat;
    logic              stop_idx;
    logic              par_bit;
    logic              bit_done;
    logic              frame_end;
    logic              tx_d;

    function automatic logic [DIV_W-1:0] bit_load(input logic [DIV_W-1:0] div);
        logic [DIV_W-1:0] v;
        v = (div == '0) ? '0 : div - 1'b1;
        return v;
    endfunction

    function automatic logic parity_of(input logic [DATA_W-1:0] d, input logic [1:0] mode);
        logic p;
        case (mode)
            PAR_EVEN: p = ^d;
            PAR_ODD:  p = ~^d;
            default:  p = 1'b1;
        endcase
        return p;
    endfunction

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign in_ready  = !fifo_full;
    assign busy      = (state != ST_IDLE) || (fifo_level != '0);
    assign bit_done  = (bit_cnt == '0);
    assign frame_end = (state == ST_STOP) && bit_done && (stop_idx || !stop2_lat);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            tx    <= 1'b1;
        end else begin
            state <= state_nxt;
            tx    <= tx_d;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (pop) state_nxt = ST_START;
            ST_START:  if (bit_done) state_nxt = ST_DATA;
            ST_DATA:   if (bit_done && bit_idx == LAST_BIT)
                           state_nxt = (par_lat != PAR_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_done) state_nxt = ST_STOP;
            ST_STOP:   if (frame_end) state_nxt = pop ? ST_START : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // tx_d is the line level for the current state; tx registers it one clock later
    always_comb begin
        tx_d = 1'b1;
        pop  = 1'b0;
        case (state)
            ST_IDLE:   pop  = !fifo_empty;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift[0];
            ST_PARITY: tx_d = par_bit;
            ST_STOP:   pop  = frame_end && !fifo_empty;
            default:   tx_d = 1'b1;
        endcase
    end

    // Frame datapath: word and format are captured at pop and held for the frame
    always_ff @(posedge clk) begin
        if (pop) begin
            shift     <= head;
            div_lat   <= cfg_div;
            par_lat   <= cfg_parity;
            stop2_lat <= cfg_stop2;
            par_bit   <= parity_of(head, cfg_parity);
            bit_cnt   <= bit_load(cfg_div);
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
        end else if (state != ST_IDLE) begin
            if (bit_done) begin
                bit_cnt <= bit_load(div_lat);
                if (state == ST_DATA) begin
                    shift   <= shift >> 1;
                    bit_idx <= bit_idx + 1'b1;
                end
                if (state == ST_STOP) stop_idx <= 1'b1;
            end else begin
                bit_cnt <= bit_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: drives words and formats, and compares the TX line
// every clock against a bit-stream model built from the frame format.
module tb_uart_tx_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] cfg_div = 16'd4;
    logic [1:0]  cfg_parity = 2'b00;
    logic        cfg_stop2 = 1'b0;
    logic        tx;
    logic        busy;
    logic [4:0]  fifo_level;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    uart_tx_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cfg_div    (cfg_div),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .tx         (tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line is high whenever no frame bits are outstanding in the model
    task automatic tick;
        bit e;
        @(posedge clk);
        #1;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
        chk("tx", 32'(tx), 32'(e));
    endtask

    function automatic void add_frame(input logic [7:0] w);
        int d;
        bit bits[$];
        d = (cfg_div == 16'd0) ? 1 : int'(cfg_div);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(w[i]);
        case (cfg_parity)
            2'd1: bits.push_back(($countones(w) % 2) == 1);
            2'd2: bits.push_back(($countones(w) % 2) == 0);
            2'd3: bits.push_back(1'b1);
            default: ;
        endcase
        bits.push_back(1'b1);
        if (cfg_stop2) bits.push_back(1'b1);
        foreach (bits[i]) repeat (d) exp_q.push_back(bits[i]);
    endfunction

    task automatic push_word(input logic [7:0] w, output bit acc);
        in_data  = w;
        in_valid = 1'b1;
        acc      = in_ready;
        tick();
        in_valid = 1'b0;
        if (acc) begin
            if (exp_q.size() == 0) exp_q.push_back(1'b1);
            add_frame(w);
        end
    endtask

    task automatic drain;
        int g = 0;
        while (exp_q.size() > 0 && g < 20000) begin
            tick();
            g++;
        end
        chk("drain_bound", 32'(g < 20000), 32'd1);
        tick();
        chk("drain_busy", 32'(busy), 32'd0);
        chk("drain_level", 32'(fifo_level), 32'd0);
        chk("drain_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        bit acc;
        int n;
        int g;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_ready", 32'(in_ready), 32'd1);
            chk("idle_level", 32'(fifo_level), 32'd0);
        end

        // 8N1 frame at 4 clocks per bit
        cfg_div = 16'd4; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        push_word(8'hA5, acc);
        chk("a5_level", 32'(fifo_level), 32'd1);
        chk("a5_busy", 32'(busy), 32'd1);
        drain();

        cfg_parity = 2'd1; push_word(8'h07, acc); drain();
        cfg_parity = 2'd2; push_word(8'h07, acc); drain();
        cfg_parity = 2'd3; push_word(8'h00, acc); drain();
        cfg_parity = 2'd0; cfg_stop2 = 1'b1; push_word(8'h96, acc); drain();
        cfg_stop2 = 1'b0;

        // Divisor change while a frame is on the line
        push_word(8'h3C, acc);
        repeat (10) tick();
        cfg_div = 16'd8;
        push_word(8'hC3, acc);
        drain();
        cfg_div = 16'd0;
        push_word(8'h5A, acc);
        drain();

        // Fill the FIFO behind a slow frame
        cfg_div = 16'd1000;
        push_word(8'h11, acc);
        tick();
        cfg_div = 16'd2;
        for (int i = 0; i < 17; i++) begin
            push_word(8'h20 + 8'(i), acc);
            chk("fill_accept", 32'(acc), 32'(i < 16));
            if (i == 15) begin
                chk("fill_level", 32'(fifo_level), 32'd16);
                chk("fill_ready", 32'(in_ready), 32'd0);
            end
        end
        chk("fill_level_after", 32'(fifo_level), 32'd16);
        drain();

        // Random formats and bursts
        for (int r = 0; r < 4; r++) begin
            cfg_div    = 16'($urandom_range(1, 6));
            cfg_parity = 2'($urandom_range(0, 3));
            cfg_stop2  = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 5);
            for (int k = 0; k < n; k++) begin
                push_word(8'($urandom), acc);
                repeat ($urandom_range(0, 3)) tick();
            end
            drain();
        end

        // Reset during the data bits of the second of three queued frames
        cfg_div = 16'd4; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        push_word(8'hF0, acc);
        push_word(8'h0F, acc);
        push_word(8'h55, acc);
        g = 0;
        while (exp_q.size() > 60 && g < 1000) begin
            tick();
            g++;
        end
        chk("rst_reach_bound", 32'(g < 1000), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        repeat (100) tick();
        chk("rst_quiet_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with a word FIFO, runtime baud divisor and runtime frame format. Sits between the Wishbone UART register block, which pushes words and drives the configuration, and the board TX pin. It replaces the fixed 8N1 transmitter. Compile-time parameters set the word width and buffering; the configuration inputs set the divisor, parity and stop bits.

## Interface
- DATA_W, 8: data bits per frame, legal range 5..9, sent LSB first
- FIFO_DEPTH, 16: FIFO entries, power of two, minimum 2
- DIV_W, 16: divisor width
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_data  in  DATA_W  word to transmit
- in_valid  in  1  in_data is valid
- in_ready  out  1  FIFO can accept a word; equals !full
- cfg_div  in  DIV_W  clocks per bit; 0 is treated as 1
- cfg_parity  in  2  parity mode: 00 none, 01 even, 10 odd, 11 mark (always 1)
- cfg_stop2  in  1  1 = two stop bits, 0 = one stop bit
- tx  out  1  serial line, idles high
- busy  out  1  high while a frame is in progress or the FIFO is non-empty
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- One clock; reset is synchronous and active-high.
- Reset values: tx=1, busy=0, in_ready=1, fifo_level=0. FSM is in IDLE and the FIFO is emptied.
- Push: a word enters the FIFO on any edge where in_valid && in_ready.
- When full, in_ready=0 and the push is refused, even on a cycle where a pop occurs. in_ready is derived from registered occupancy.
- FSM states are IDLE, START, DATA, PARITY, STOP.
- IDLE: if the FIFO is non-empty, pop the head and go to START.
  - On the same edge, latch the word, cfg_div, cfg_parity and cfg_stop2.
  - Configuration changes mid-frame have no effect until the next frame.
- START: tx=0 for one bit time.
- DATA: DATA_W bits, LSB first, with a bit counter.
- PARITY: entered only if the latched mode is not 00. The bit is XOR of the data for even, its inverse for odd, and 1 for mark.
- STOP: tx=1 for one or two bit times.
  - At the final clock of the last stop bit, if the FIFO is non-empty, pop and go straight to START. There is no idle gap.
  - Otherwise go to IDLE.
- Bit time: a down-counter loaded with max(cfg_div,1)-1 at each bit start. The bit ends when the counter reaches 0.
- tx is registered and glitch-free.
- busy = (state != IDLE) || (fifo_level != 0).

## Timing
- Word accepted on edge E (FIFO was empty, FSM in IDLE):
  - Pop on edge E+1.
  - tx falls after edge E+2.
  - Start-bit latency is 2 clocks.
- Frame length is cfg_div × (1 + DATA_W + P + S) clocks, where P is 0 or 1 and S is 1 or 2.
- Back-to-back words: the stop bit of frame n is followed immediately by the start bit of frame n+1, with no extra clock.
- fifo_level updates one edge after a push or pop. A simultaneous push and pop leaves it unchanged.
- Reset asserted mid-frame: on the next edge tx=1, the FSM is in IDLE and the FIFO is empty. The partial frame is abandoned and no stop bit is completed.
- FIFO pointers wrap modulo FIFO_DEPTH. full and empty come from the occupancy count, not from pointer equality alone.

## Structure
- Shared header uart_pkg.vh holds:
  - parity encodings PAR_NONE/PAR_EVEN/PAR_ODD/PAR_MARK
  - FSM state localparams
  - default divisor 234 (27 MHz, 115200 baud)
- Sub-module sync_fifo, parametrised by width and depth, with push/pop/full/empty/level. It is reusable by the future receiver.
- The FSM, bit-time counter and shift register stay in uart_tx_fifo.

## Test plan
- Reset, then idle for 50 clocks -> tx=1, busy=0, in_ready=1, fifo_level=0 throughout.
- Push 0xA5 with div=4, no parity, 1 stop:
  - tx is 0 for 4 clocks, then bits 1,0,1,0,0,1,0,1 at 4 clocks each, then stop 1 for 4 clocks.
  - 40 clocks total; busy falls on the cycle after the stop bit ends.
- Push 0x07 with even parity -> parity bit 1. Push 0x07 with odd parity -> parity bit 0. Mark parity with 0x00 -> parity bit 1. Two stop bits -> stop high for 2×div.
- Push 17 words while the FSM is stalled in a long frame (div=1000):
  - in_ready drops after the 16th accepted word and the 17th is refused.
  - fifo_level reads 16.
  - All 16 words are later sent in order with no inter-frame gap.
- Change cfg_div from 4 to 8 mid-frame -> the current frame keeps 4 clocks/bit and the next frame uses 8. cfg_div=0 behaves as 1.
- Assert rst during the DATA state of the second of three queued words -> tx=1 the next cycle, fifo_level=0, and no further frames are sent.
